dbf_rx_sequencer: RTL and testbench
===================================

# dbf_rx_sequencer

Firing-cycle controller for the DBF channel array. On each trigger it drives the shared `tx_en`, `start`, `dbf_lut_addr` and `dbf_lut_we` lines broadcast to every `dbf_chNN` instance. The firing cycle runs transmit window, dead time, then receive. During receive it steps the coarse/fine delay LUT address once per focal zone, so that all channels refocus in lock-step. It sits between the scan controller (trigger and configuration) and the channel bank.

## Interface
Parameters:
- `ADDR_WD`, 6: delay LUT address width; must match the channel `ADDR_WD`.
- `CNT_WD`, 16: width of the window-length counters.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `trig`  in  1  firing request, single-cycle pulse.
- `tx_len`  in  CNT_WD  transmit window length in cycles; 0 is treated as 1.
- `dead_len`  in  CNT_WD  cycles between end of TX and start of RX; 0 is allowed.
- `zone_len`  in  CNT_WD  receive samples per focal zone; 0 is treated as 1.
- `num_zones`  in  ADDR_WD  last zone index (zones 0..num_zones).
- `abort`  in  1  cancel the firing; present only with `DBF_SEQ_ABORT_EN`.
- `tx_en`  out  1  transmit window to the channels.
- `start`  out  1  receive/beamform enable to the channels.
- `dbf_lut_addr`  out  ADDR_WD  delay LUT address.
- `dbf_lut_we`  out  1  LUT update strobe: one pulse per zone.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when a firing completes.

## Operation
- States: IDLE, TX, DEAD, RX, FIN.
- Configuration inputs are captured into shadow registers on the accepted `trig`. They may change freely while `busy` is high.
- IDLE: if `trig` is high, capture the configuration, load the counter with max(`tx_len`,1)-1, and go to TX.
  - `trig` while `busy` is high is ignored. It is not queued.
- TX: `tx_en`=1. When the counter reaches 0:
  - go to DEAD if `dead_len`≠0, loading the counter with `dead_len`-1;
  - otherwise go straight to RX.
- DEAD: all outputs idle. When the counter reaches 0, go to RX.
- RX entry:
  - `dbf_lut_addr`=0, `dbf_lut_we`=1 for that first cycle;
  - zone counter = max(`zone_len`,1)-1, zone index = 0.
- RX: `start`=1 every cycle.
  - When the zone counter hits 0 and zone index < `num_zones`: increment the zone index, drive it on `dbf_lut_addr`, pulse `dbf_lut_we`, and reload the zone counter.
  - When the zone counter hits 0 and zone index = `num_zones`: go to FIN.
- FIN: `done`=1 for one cycle, then IDLE. `dbf_lut_addr` holds the last zone index until the next firing.
- Total RX cycles = (`num_zones`+1) × max(`zone_len`,1).
- The zone index never wraps. `num_zones`=2^ADDR_WD-1 is legal, and the final address is all ones.
- Reset (any state, mid-firing included): next cycle is IDLE and every output is 0 (`dbf_lut_addr`=0).

## Timing
- Reset values: `tx_en`, `start`, `dbf_lut_we`, `busy`, `done` = 0; `dbf_lut_addr` = 0.
- All outputs are registered.
- `trig` sampled at edge k gives `tx_en`=1 and `busy`=1 from cycle k+1, for exactly max(`tx_len`,1) cycles.
- `tx_en` and `start` are never high in the same cycle. Between them there are `dead_len` idle cycles.
- First `start` cycle coincides with the first `dbf_lut_we` pulse (addr 0).
- `dbf_lut_we` is never high outside RX.
- `done` is asserted in the cycle after the last `start` cycle. `busy` drops in the cycle after `done`.
- Back-to-back: `trig` in the `done` cycle is ignored. `trig` in the next cycle (IDLE) is accepted.

## Configuration
- `DBF_SEQ_ABORT_EN` defined:
  - `abort` port exists.
  - `abort`=1 in TX, DEAD or RX forces FIN on the next edge. The remaining `tx_en`/`start` cycles are dropped, and `done` pulses normally.
  - `abort` in IDLE or FIN has no effect.
  - `abort` and `trig` together in IDLE: `trig` wins.
- Undefined: the port is absent and every firing always runs to completion.

## Structure
- Shared package `dbf_pkg`:
  - state encoding enum (IDLE=0, TX=1, DEAD=2, RX=3, FIN=4);
  - `ADDR_WD`/`CNT_WD` defaults, consistent with the channel `param.h` values.
- Sub-module `dbf_seq_cnt`: a loadable down-counter with a zero flag. It is instantiated twice: one for the window (TX/DEAD), one for the zone.
- Top level holds the FSM, the shadow registers and the output registers.

## Test plan
- Basic firing with `tx_len`=4, `dead_len`=3, `zone_len`=5, `num_zones`=2:
  - `tx_en` high for 4 cycles, 3 idle cycles, then `start` high for 15 cycles;
  - `dbf_lut_we` pulses at RX cycles 0, 5, 10 with addr 0, 1, 2;
  - `done` pulses once.
- `tx_len`=0, `dead_len`=0, `zone_len`=0, `num_zones`=0 → 1 `tx_en` cycle, immediately followed by 1 `start` cycle with `dbf_lut_we` at addr 0, then `done`.
- `trig` repeated at every cycle of a firing → exactly one firing runs. Change `zone_len` from 5 to 9 mid-RX → zone spacing stays 5.
- `num_zones`=63 (`ADDR_WD`=6), `zone_len`=2 → 64 strobes; the last address is 63; `start` runs 128 cycles; no wrap to 0.
- Deassert `rst_n` for 1 cycle mid-RX → next cycle all outputs are 0 and the state is IDLE. A following `trig` gives a clean firing from addr 0.
- With `DBF_SEQ_ABORT_EN`: `abort` at RX cycle 3 → `start` is low from the next cycle, `done` pulses, `busy` drops one cycle later.

Source files
------------

// File: rtl/dbf_pkg.sv
// dbf_pkg: shared definitions for the DBF firing-cycle sequencer and channel bank.
// Holds the sequencer state encoding and the default address/counter widths,
// which must stay aligned with the channel-side ADDR_WD.
package dbf_pkg;

  // Delay LUT address width, shared with every dbf_chNN instance.
  localparam int DBF_ADDR_WD = 6;
  // Width of the TX/DEAD window and zone-length counters.
  localparam int DBF_CNT_WD  = 16;

  // Firing-cycle FSM states; the encoding is fixed so debug taps stay stable.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TX   = 3'd1,
    ST_DEAD = 3'd2,
    ST_RX   = 3'd3,
    ST_FIN  = 3'd4
  } dbf_seq_state_e;

endpackage

// File: rtl/dbf_seq_cnt.sv
// dbf_seq_cnt: loadable down-counter with a zero flag.
// A load takes priority over a decrement, and the count saturates at zero,
// so the zero flag stays valid for the cycle the FSM acts on it.
module dbf_seq_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Count register: synchronous reset, load, then saturating decrement.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dbf_rx_sequencer.sv
// dbf_rx_sequencer: firing-cycle controller for the DBF channel array.
// Sequence per trigger: TX window, dead time, RX with one delay-LUT update
// per focal zone, then a one-cycle done pulse. All outputs are registered.
// Optional feature macro: DBF_SEQ_ABORT_EN adds the 'abort' input, which
// cuts a running firing short and jumps to FIN.
module dbf_rx_sequencer
  import dbf_pkg::*;
#(
  parameter int ADDR_WD = DBF_ADDR_WD,
  parameter int CNT_WD  = DBF_CNT_WD
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trig,
  input  logic [CNT_WD-1:0]  tx_len,
  input  logic [CNT_WD-1:0]  dead_len,
  input  logic [CNT_WD-1:0]  zone_len,
  input  logic [ADDR_WD-1:0] num_zones,
`ifdef DBF_SEQ_ABORT_EN
  input  logic               abort,
`endif
  output logic               tx_en,
  output logic               start,
  output logic [ADDR_WD-1:0] dbf_lut_addr,
  output logic               dbf_lut_we,
  output logic               busy,
  output logic               done
);

  dbf_seq_state_e     r_state;

  // Shadow copies of the configuration, frozen for the whole firing.
  logic [CNT_WD-1:0]  r_dead_len;
  logic [CNT_WD-1:0]  r_zone_ld;
  logic [ADDR_WD-1:0] r_num_zones;

  logic               r_tx_en;
  logic               r_start;
  logic [ADDR_WD-1:0] r_addr;
  logic               r_we;
  logic               r_busy;
  logic               r_done;

  logic               w_abort;
  logic               w_win_zero;
  logic               w_zone_zero;
  logic               w_win_load;
  logic [CNT_WD-1:0]  w_win_val;
  logic               w_win_dec;
  logic               w_zone_load;
  logic               w_zone_dec;

`ifdef DBF_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Counter control: which window/zone reload happens on this edge.
  always_comb begin
    w_win_load  = 1'b0;
    w_win_val   = '0;
    w_zone_load = 1'b0;
    w_win_dec   = (r_state == ST_TX) || (r_state == ST_DEAD);
    w_zone_dec  = (r_state == ST_RX);
    case (r_state)
      ST_IDLE: begin
        if (trig) begin
          w_win_load = 1'b1;
          w_win_val  = (tx_len == '0) ? '0 : (tx_len - CNT_WD'(1));
        end else begin
          w_win_load = 1'b0;
        end
      end
      ST_TX: begin
        if (w_win_zero && (r_dead_len != '0)) begin
          w_win_load = 1'b1;
          w_win_val  = r_dead_len - CNT_WD'(1);
        end else if (w_win_zero) begin
          w_zone_load = 1'b1;
        end else begin
          w_win_load = 1'b0;
        end
      end
      ST_DEAD: begin
        if (w_win_zero) begin
          w_zone_load = 1'b1;
        end else begin
          w_zone_load = 1'b0;
        end
      end
      ST_RX: begin
        if (w_zone_zero && (r_addr < r_num_zones)) begin
          w_zone_load = 1'b1;
        end else begin
          w_zone_load = 1'b0;
        end
      end
      default: begin
        w_win_load  = 1'b0;
        w_zone_load = 1'b0;
      end
    endcase
  end

  dbf_seq_cnt #(.W(CNT_WD)) u_win_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_win_load),
    .i_load_val (w_win_val),
    .i_dec      (w_win_dec),
    .o_zero     (w_win_zero)
  );

  dbf_seq_cnt #(.W(CNT_WD)) u_zone_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_zone_load),
    .i_load_val (r_zone_ld),
    .i_dec      (w_zone_dec),
    .o_zero     (w_zone_zero)
  );

  // Firing FSM with shadow capture and registered channel-facing outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_dead_len  <= '0;
      r_zone_ld   <= '0;
      r_num_zones <= '0;
      r_tx_en     <= 1'b0;
      r_start     <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (trig) begin
            r_dead_len  <= dead_len;
            r_zone_ld   <= (zone_len == '0) ? '0 : (zone_len - CNT_WD'(1));
            r_num_zones <= num_zones;
            r_tx_en     <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_TX;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_TX: begin
          if (w_abort) begin
            r_tx_en <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else if (w_win_zero && (r_dead_len != '0)) begin
            r_tx_en <= 1'b0;
            r_state <= ST_DEAD;
          end else if (w_win_zero) begin
            // Zero dead time: first RX cycle directly follows TX.
            r_tx_en <= 1'b0;
            r_start <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= '0;
            r_state <= ST_RX;
          end else begin
            r_state <= ST_TX;
          end
        end
        ST_DEAD: begin
          if (w_abort) begin
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else if (w_win_zero) begin
            r_start <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= '0;
            r_state <= ST_RX;
          end else begin
            r_state <= ST_DEAD;
          end
        end
        ST_RX: begin
          if (w_abort) begin
            r_start <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else if (w_zone_zero && (r_addr < r_num_zones)) begin
            // Next focal zone; compare-before-increment means no wrap.
            r_addr  <= r_addr + ADDR_WD'(1);
            r_we    <= 1'b1;
            r_state <= ST_RX;
          end else if (w_zone_zero) begin
            r_start <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_FIN;
          end else begin
            r_state <= ST_RX;
          end
        end
        ST_FIN: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_tx_en <= 1'b0;
          r_start <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_en        = r_tx_en;
  assign start        = r_start;
  assign dbf_lut_addr = r_addr;
  assign dbf_lut_we   = r_we;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_dbf_rx_sequencer.sv
// tb_dbf_rx_sequencer: directed firings with hand-computed expectations.
module tb_dbf_rx_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trig;
  logic [15:0] tx_len;
  logic [15:0] dead_len;
  logic [15:0] zone_len;
  logic [5:0]  num_zones;
`ifdef DBF_SEQ_ABORT_EN
  logic        abort;
`endif
  logic        tx_en;
  logic        start;
  logic [5:0]  dbf_lut_addr;
  logic        dbf_lut_we;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  dbf_rx_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trig         (trig),
    .tx_len       (tx_len),
    .dead_len     (dead_len),
    .zone_len     (zone_len),
    .num_zones    (num_zones),
`ifdef DBF_SEQ_ABORT_EN
    .abort        (abort),
`endif
    .tx_en        (tx_en),
    .start        (start),
    .dbf_lut_addr (dbf_lut_addr),
    .dbf_lut_we   (dbf_lut_we),
    .busy         (busy),
    .done         (done)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Per-firing observations.
  int n_tx, n_dead, n_start, n_done, n_overlap, n_we_out, n_busy_bad;
  int we_pos[$];
  int we_adr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one firing and record what the channel bus saw, cycle by cycle.
  task automatic fire(input string tag, input int tl, input int dl, input int zl,
                      input int nz, input bit hold, input int chg_at,
                      input int rst_at, input int abort_at, input int exp_addr);
    int cyc;
    bit fin;
    bit abort_sent;
    n_tx = 0; n_dead = 0; n_start = 0; n_done = 0;
    n_overlap = 0; n_we_out = 0; n_busy_bad = 0;
    we_pos.delete();
    we_adr.delete();
    abort_sent = 1'b0;
    @(negedge clk);
    tx_len    = 16'(tl);
    dead_len  = 16'(dl);
    zone_len  = 16'(zl);
    num_zones = 6'(nz);
    trig      = 1'b1;
    @(negedge clk);
    if (!hold) trig = 1'b0;
    chk({tag, "_latency"}, {30'd0, tx_en, busy}, 32'd3);
    fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < 3000) begin
`ifdef DBF_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      if (tx_en) n_tx++;
      if (tx_en && start) n_overlap++;
      if (busy && !tx_en && !start && !done && n_tx > 0 && n_start == 0) n_dead++;
      if (dbf_lut_we && !start) n_we_out++;
      if ((tx_en || start || done) && !busy) n_busy_bad++;
      if (start) begin
        if (dbf_lut_we) begin
          we_pos.push_back(n_start);
          we_adr.push_back(int'(dbf_lut_addr));
        end
        n_start++;
      end
      if (chg_at >= 0 && n_start == chg_at) zone_len = 16'd9;
`ifdef DBF_SEQ_ABORT_EN
      if (abort_at >= 0 && n_start == abort_at + 1 && !abort_sent) begin
        abort      = 1'b1;
        abort_sent = 1'b1;
      end
`endif
      if (rst_at >= 0 && n_start == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        chk({tag, "_rst_outputs"},
            {21'd0, tx_en, start, dbf_lut_we, busy, done, dbf_lut_addr}, 32'd0);
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        n_done++;
        @(negedge clk);
        chk({tag, "_busy_after_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_single"}, {31'd0, done}, 32'd0);
        chk({tag, "_addr_hold"}, {26'd0, dbf_lut_addr}, 32'(exp_addr));
        trig = 1'b0;
        fin  = 1'b1;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    trig = 1'b0;
    chk({tag, "_completed"}, {31'd0, fin}, 32'd1);
    chk({tag, "_no_overlap"}, 32'(n_overlap), 32'd0);
    chk({tag, "_we_outside_rx"}, 32'(n_we_out), 32'd0);
    chk({tag, "_busy_cover"}, 32'(n_busy_bad), 32'd0);
  endtask

  // Compare recorded LUT strobes against nz+1 zones spaced z cycles apart.
  task automatic chk_zones(input string tag, input int nz, input int z);
    int bad;
    bad = 0;
    chk({tag, "_we_count"}, 32'(we_pos.size()), 32'(nz + 1));
    foreach (we_pos[i]) begin
      if (we_pos[i] != i * z || we_adr[i] != i) bad++;
    end
    chk({tag, "_we_pattern"}, 32'(bad), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    trig      = 1'b0;
    tx_len    = 16'd0;
    dead_len  = 16'd0;
    zone_len  = 16'd0;
    num_zones = 6'd0;
`ifdef DBF_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_outputs", {21'd0, tx_en, start, dbf_lut_we, busy, done, dbf_lut_addr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {21'd0, tx_en, start, dbf_lut_we, busy, done, dbf_lut_addr}, 32'd0);

    // Basic firing: 4 TX, 3 dead, 3 zones of 5 samples.
    fire("basic", 4, 3, 5, 2, 1'b0, -1, -1, -1, 2);
    chk("basic_tx", 32'(n_tx), 32'd4);
    chk("basic_dead", 32'(n_dead), 32'd3);
    chk("basic_start", 32'(n_start), 32'd15);
    chk("basic_done", 32'(n_done), 32'd1);
    chk_zones("basic", 2, 5);

    // All-zero configuration: 1 TX cycle, straight into 1 RX cycle.
    fire("zeros", 0, 0, 0, 0, 1'b0, -1, -1, -1, 0);
    chk("zeros_tx", 32'(n_tx), 32'd1);
    chk("zeros_dead", 32'(n_dead), 32'd0);
    chk("zeros_start", 32'(n_start), 32'd1);
    chk("zeros_done", 32'(n_done), 32'd1);
    chk_zones("zeros", 0, 1);

    // trig held every cycle and zone_len changed to 9 mid-RX: one firing, spacing 5.
    fire("hold", 2, 1, 5, 2, 1'b1, 2, -1, -1, 2);
    chk("hold_tx", 32'(n_tx), 32'd2);
    chk("hold_dead", 32'(n_dead), 32'd1);
    chk("hold_start", 32'(n_start), 32'd15);
    chk("hold_done", 32'(n_done), 32'd1);
    chk_zones("hold", 2, 5);

    // Full address range: 64 zones of 2 samples, last address 63.
    fire("maxz", 1, 0, 2, 63, 1'b0, -1, -1, -1, 63);
    chk("maxz_start", 32'(n_start), 32'd128);
    chk("maxz_done", 32'(n_done), 32'd1);
    chk_zones("maxz", 63, 2);

    // Reset mid-RX, then a clean firing from address 0.
    fire("rst", 2, 1, 4, 3, 1'b0, -1, 6, -1, 0);
    @(negedge clk);
    chk("rst_idle_after", {21'd0, tx_en, start, dbf_lut_we, busy, done, dbf_lut_addr}, 32'd0);
    fire("post_rst", 1, 0, 3, 1, 1'b0, -1, -1, -1, 1);
    chk("post_rst_tx", 32'(n_tx), 32'd1);
    chk("post_rst_start", 32'(n_start), 32'd6);
    chk("post_rst_done", 32'(n_done), 32'd1);
    chk_zones("post_rst", 1, 3);

`ifdef DBF_SEQ_ABORT_EN
    // Abort during RX cycle 3: start stops after 4 cycles, done still pulses.
    fire("abort", 2, 2, 4, 3, 1'b0, -1, -1, 3, 0);
    chk("abort_tx", 32'(n_tx), 32'd2);
    chk("abort_start", 32'(n_start), 32'd4);
    chk("abort_done", 32'(n_done), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
